// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to APB bridge: FSM states and the
// request/response word layouts used by both sides of the request/response FIFOs.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam int BR_ADDR_W = 32;
  localparam int BR_DATA_W = 32;
  localparam int BR_STRB_W = BR_DATA_W / 8;

  // Request word {write, prot[2:0], addr, wdata, strb}, MSB first
  localparam int REQ_STRB_LSB  = 0;
  localparam int REQ_WDATA_LSB = REQ_STRB_LSB + BR_STRB_W;
  localparam int REQ_ADDR_LSB  = REQ_WDATA_LSB + BR_DATA_W;
  localparam int REQ_PROT_LSB  = REQ_ADDR_LSB + BR_ADDR_W;
  localparam int REQ_WRITE_BIT = REQ_PROT_LSB + 3;
  localparam int REQ_BITS      = REQ_WRITE_BIT + 1;

  // Response word {write, slverr, rdata}
  localparam int RSP_RDATA_LSB  = 0;
  localparam int RSP_SLVERR_BIT = RSP_RDATA_LSB + BR_DATA_W;
  localparam int RSP_WRITE_BIT  = RSP_SLVERR_BIT + 1;
  localparam int RSP_BITS       = RSP_WRITE_BIT + 1;

  typedef struct packed {
    logic                 write;
    logic [2:0]           prot;
    logic [BR_ADDR_W-1:0] addr;
    logic [BR_DATA_W-1:0] wdata;
    logic [BR_STRB_W-1:0] strb;
  } apb_req_t;

  typedef struct packed {
    logic                 write;
    logic                 slverr;
    logic [BR_DATA_W-1:0] rdata;
  } apb_rsp_t;

  function automatic logic [REQ_BITS-1:0] pack_req(input apb_req_t r);
    return r;
  endfunction

  function automatic apb_req_t unpack_req(input logic [REQ_BITS-1:0] w);
    return w;
  endfunction

  function automatic logic [RSP_BITS-1:0] pack_rsp(input apb_rsp_t r);
    return r;
  endfunction

  function automatic apb_rsp_t unpack_rsp(input logic [RSP_BITS-1:0] w);
    return w;
  endfunction

endpackage

// File: rtl/apb_fifo_master_if.sv
// APB4 bus bundle between the FIFO-driven requester and a completer.
interface apb_fifo_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [2:0]            pprot;
  logic                  pready;
  logic                  pslverr;
  logic [DATA_W-1:0]     prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_fifo_master.sv
// APB4 requester: pops one request word, runs one SETUP/ACCESS transfer with
// optional timeout, and pushes one response word per request.
module apb_fifo_master
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  localparam int STRB_W = DATA_W / 8,
  localparam int REQ_W  = 1 + 3 + ADDR_W + DATA_W + STRB_W,
  localparam int RSP_W  = 2 + DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_empty,
  input  logic [REQ_W-1:0]     req_data,
  output logic                 req_pop,
  input  logic                 rsp_full,
  output logic                 rsp_push,
  output logic [RSP_W-1:0]     rsp_data,
  apb_fifo_master_if.master    apb
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam int WDATA_LSB = STRB_W;
  localparam int ADDR_LSB  = WDATA_LSB + DATA_W;
  localparam int PROT_LSB  = ADDR_LSB + ADDR_W;
  localparam int WRITE_BIT = PROT_LSB + 3;

  apb_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;
  logic [DATA_W-1:0] rd_val;

  // Popping only with a free response slot guarantees the RESP push never blocks.
  assign req_pop     = !rst && (state == ST_IDLE) && !req_empty && !rsp_full;
  assign timeout_hit = TO_EN && (wait_cnt == LIMIT);
  assign apb.psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign apb.penable = (state == ST_ACCESS);
  assign rsp_push    = (state == ST_RESP);

  always_comb begin
    rd_val = '0;
    if (!apb.pwrite) rd_val = apb.prdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      apb.pwrite  <= 1'b0;
      apb.pprot   <= '0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      apb.pstrb   <= '0;
      rsp_data    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_pop) begin
            apb.pwrite <= req_data[WRITE_BIT];
            apb.pprot  <= req_data[PROT_LSB +: 3];
            apb.paddr  <= req_data[ADDR_LSB +: ADDR_W];
            apb.pwdata <= req_data[WDATA_LSB +: DATA_W];
            apb.pstrb  <= req_data[WRITE_BIT] ? req_data[0 +: STRB_W] : '0;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          wait_cnt <= '0;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready takes priority over a timeout landing in the same cycle
          if (apb.pready) begin
            rsp_data <= {apb.pwrite, apb.pslverr, rd_val};
            state    <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_data <= {apb.pwrite, 1'b1, {DATA_W{1'b0}}};
            state    <= ST_RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fifo_master.sv
// Self-checking bench for apb_fifo_master: FIFO and completer models plus a
// request-level reference model of the expected responses and bus activity.
module tb_apb_fifo_master;
  import apb_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;
  localparam int REQ_W = 1 + 3 + AW + DW + SW;
  localparam int RSP_W = 2 + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rsp_full = 1'b0;
  logic req_empty, req_pop, rsp_push;
  logic [REQ_W-1:0] req_data;
  logic [RSP_W-1:0] rsp_data;

  apb_fifo_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_fifo_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_empty(req_empty), .req_data(req_data),
    .req_pop(req_pop), .rsp_full(rsp_full), .rsp_push(rsp_push),
    .rsp_data(rsp_data), .apb(bus)
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int err_n = 0;
  int cyc = 0;

  // request FIFO model (first-word fall-through)
  logic [REQ_W-1:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign req_empty = (wr_ptr == rd_ptr);
  assign req_data  = fifo_mem[rd_ptr % 64];

  int pop_cyc_q[$];
  always @(posedge clk) begin
    if (req_pop) begin
      pop_cyc_q.push_back(cyc);
      rd_ptr <= rd_ptr + 1;
    end
    cyc <= cyc + 1;
  end

  // completer stimulus table, one entry per transfer in order
  int              t_wait[$];
  logic [DW-1:0]   t_rdata[$];
  logic            t_err[$];
  int              cur_wait = 0;
  logic [DW-1:0]   cur_rdata = '0;
  logic            cur_err = 1'b0;
  int              acc_n = 0;
  logic [REQ_W-1:0] setup_snap = '0;
  logic [REQ_W-1:0] now_snap;

  // observation logs
  logic [REQ_W-1:0] obs_bus_q[$];
  int               len_q[$];
  int               setup_cyc_q[$];
  int               push_cyc_q[$];
  logic [RSP_W-1:0] got_q[$];
  int               unstable_n = 0;
  int               push_full_n = 0;

  // reference model expectations
  logic [RSP_W-1:0] exp_q[$];
  logic [REQ_W-1:0] exp_bus_q[$];
  int               exp_len_q[$];

  always @(negedge clk) begin
    now_snap = {bus.pwrite, bus.pprot, bus.paddr, bus.pwdata, bus.pstrb};
    if (rsp_push) begin
      got_q.push_back(rsp_data);
      push_cyc_q.push_back(cyc);
      if (rsp_full) push_full_n++;
    end
    if (bus.psel && !bus.penable) begin
      setup_snap = now_snap;
      obs_bus_q.push_back(now_snap);
      setup_cyc_q.push_back(cyc);
      if (t_wait.size() > 0) begin
        cur_wait  = t_wait.pop_front();
        cur_rdata = t_rdata.pop_front();
        cur_err   = t_err.pop_front();
      end else begin
        cur_wait = 0; cur_rdata = '0; cur_err = 1'b0;
      end
    end
    if (bus.psel && bus.penable) begin
      acc_n++;
      if (now_snap != setup_snap) unstable_n++;
      if (acc_n == cur_wait + 1) begin
        bus.pready = 1'b1; bus.prdata = cur_rdata; bus.pslverr = cur_err;
      end else begin
        bus.pready = 1'b0; bus.prdata = $urandom; bus.pslverr = 1'($urandom_range(0, 1));
      end
    end else begin
      if (acc_n != 0) len_q.push_back(acc_n);
      acc_n = 0;
      bus.pready  = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_cyc_q.delete(); obs_bus_q.delete(); len_q.delete(); setup_cyc_q.delete();
    push_cyc_q.delete(); got_q.delete(); exp_q.delete(); exp_bus_q.delete();
    exp_len_q.delete(); unstable_n = 0; push_full_n = 0;
  endtask

  // Queue one request and derive its expected outcome from the transfer rules.
  task automatic enqueue(input logic w, input logic [2:0] prot, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] st, input int wt,
                         input logic [DW-1:0] rd, input logic er);
    apb_req_t r;
    apb_rsp_t s;
    bit timed;
    r = '{write: w, prot: prot, addr: addr, wdata: wd, strb: st};
    fifo_mem[wr_ptr % 64] = pack_req(r);
    wr_ptr++;
    t_wait.push_back(wt); t_rdata.push_back(rd); t_err.push_back(er);
    r.strb = w ? st : '0;
    exp_bus_q.push_back(pack_req(r));
    timed = (wt >= TO);
    s.write  = w;
    s.slverr = timed ? 1'b1 : er;
    s.rdata  = (timed || w) ? '0 : rd;
    exp_q.push_back(pack_rsp(s));
    exp_len_q.push_back(timed ? TO : wt + 1);
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) break;
      step();
    end
    ok = (got_q.size() >= n);
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_full = 1'b0;
    repeat (3) step();
    cmp_n++; if ({req_pop, rsp_push} !== 2'b00) begin err_n++; $display("FAIL reset_pop_push: got %b expected 00", {req_pop, rsp_push}); end
    cmp_n++; if ({bus.psel, bus.penable} !== 2'b00) begin err_n++; $display("FAIL reset_psel_penable: got %b expected 00", {bus.psel, bus.penable}); end
    cmp_n++; if ({bus.pwrite, bus.pprot, bus.paddr, bus.pwdata, bus.pstrb} !== '0) begin err_n++; $display("FAIL reset_bus: got %h expected 0", {bus.pwrite, bus.pprot, bus.paddr, bus.pwdata, bus.pstrb}); end
    cmp_n++; if (rsp_data !== '0) begin err_n++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_nowait();
    bit ok;
    clear_logs();
    enqueue(1'b1, 3'd0, 32'h10, 32'hDEADBEEF, 4'hF, 0, $urandom, 1'b0);
    wait_rsp(1, 50, ok);
    cmp_n++; if (!ok) begin err_n++; $display("FAIL wr_rsp_count: got %0d expected 1", got_q.size()); end
    else begin
      cmp_n++; if (got_q[0] !== 34'h2_0000_0000) begin err_n++; $display("FAIL wr_rsp: got %h expected %h", got_q[0], 34'h2_0000_0000); end
      cmp_n++; if (setup_cyc_q[0] !== pop_cyc_q[0] + 1) begin err_n++; $display("FAIL wr_setup_lat: got %0d expected %0d", setup_cyc_q[0], pop_cyc_q[0] + 1); end
      cmp_n++; if (len_q[0] !== 1) begin err_n++; $display("FAIL wr_access_len: got %0d expected 1", len_q[0]); end
      cmp_n++; if (push_cyc_q[0] !== setup_cyc_q[0] + 2) begin err_n++; $display("FAIL wr_push_lat: got %0d expected %0d", push_cyc_q[0], setup_cyc_q[0] + 2); end
      cmp_n++; if (obs_bus_q[0] !== exp_bus_q[0]) begin err_n++; $display("FAIL wr_bus: got %h expected %h", obs_bus_q[0], exp_bus_q[0]); end
    end
  endtask

  task automatic test_read_wait();
    bit ok;
    logic [31:0] rv;
    clear_logs();
    rv = $urandom;
    enqueue(1'b0, rv[2:0], 32'h24, $urandom, 4'hB, 3, 32'hA5A5A5A5, 1'b0);
    wait_rsp(1, 50, ok);
    cmp_n++; if (!ok) begin err_n++; $display("FAIL rd_rsp_count: got %0d expected 1", got_q.size()); end
    else begin
      cmp_n++; if (got_q[0] !== exp_q[0]) begin err_n++; $display("FAIL rd_rsp: got %h expected %h", got_q[0], exp_q[0]); end
      cmp_n++; if (len_q[0] !== 4) begin err_n++; $display("FAIL rd_access_len: got %0d expected 4", len_q[0]); end
      cmp_n++; if (obs_bus_q[0][SW-1:0] !== '0) begin err_n++; $display("FAIL rd_pstrb: got %h expected 0", obs_bus_q[0][SW-1:0]); end
      cmp_n++; if (obs_bus_q[0] !== exp_bus_q[0]) begin err_n++; $display("FAIL rd_bus: got %h expected %h", obs_bus_q[0], exp_bus_q[0]); end
      cmp_n++; if (unstable_n !== 0) begin err_n++; $display("FAIL rd_stable: got %0d changes expected 0", unstable_n); end
    end
  endtask

  task automatic test_error();
    bit ok;
    clear_logs();
    enqueue(1'b1, 3'd5, $urandom, $urandom, 4'h3, int'($urandom_range(0, 3)), $urandom, 1'b1);
    enqueue(1'b0, 3'd1, $urandom, $urandom, 4'hF, 0, $urandom, 1'b0);
    wait_rsp(2, 60, ok);
    cmp_n++; if (!ok) begin err_n++; $display("FAIL err_rsp_count: got %0d expected 2", got_q.size()); end
    else begin
      cmp_n++; if (got_q[0] !== 34'h3_0000_0000) begin err_n++; $display("FAIL err_rsp: got %h expected %h", got_q[0], 34'h3_0000_0000); end
      cmp_n++; if (got_q[1] !== exp_q[1]) begin err_n++; $display("FAIL err_next_rsp: got %h expected %h", got_q[1], exp_q[1]); end
      cmp_n++; if (pop_cyc_q[1] !== push_cyc_q[0] + 1) begin err_n++; $display("FAIL err_next_pop: got %0d expected %0d", pop_cyc_q[1], push_cyc_q[0] + 1); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] rv;
    clear_logs();
    rsp_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rv = $urandom;
      enqueue(rv[0], rv[3:1], $urandom, $urandom, rv[7:4], int'($urandom_range(0, 2)), $urandom, rv[8]);
    end
    repeat (12) step();
    cmp_n++; if (pop_cyc_q.size() !== 0) begin err_n++; $display("FAIL bp_no_pop: got %0d pops expected 0", pop_cyc_q.size()); end
    cmp_n++; if (setup_cyc_q.size() !== 0) begin err_n++; $display("FAIL bp_no_psel: got %0d transfers expected 0", setup_cyc_q.size()); end
    rsp_full = 1'b0;
    wait_rsp(3, 100, ok);
    cmp_n++; if (!ok) begin err_n++; $display("FAIL bp_rsp_count: got %0d expected 3", got_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        cmp_n++; if (got_q[i] !== exp_q[i]) begin err_n++; $display("FAIL bp_rsp%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    enqueue(1'b1, 3'd2, $urandom, $urandom, 4'hF, TO + 5, $urandom, 1'b0);
    enqueue(1'b0, 3'd3, $urandom, $urandom, 4'hF, TO - 1, 32'h1234_5678, 1'b0);
    wait_rsp(2, 80, ok);
    cmp_n++; if (!ok) begin err_n++; $display("FAIL to_rsp_count: got %0d expected 2", got_q.size()); end
    else begin
      cmp_n++; if (got_q[0] !== 34'h3_0000_0000) begin err_n++; $display("FAIL to_rsp: got %h expected %h", got_q[0], 34'h3_0000_0000); end
      cmp_n++; if (len_q[0] !== TO) begin err_n++; $display("FAIL to_access_len: got %0d expected %0d", len_q[0], TO); end
      cmp_n++; if (push_cyc_q[0] !== setup_cyc_q[0] + TO + 1) begin err_n++; $display("FAIL to_push_lat: got %0d expected %0d", push_cyc_q[0], setup_cyc_q[0] + TO + 1); end
      cmp_n++; if (got_q[1] !== 34'h0_1234_5678) begin err_n++; $display("FAIL to_edge_rsp: got %h expected %h", got_q[1], 34'h0_1234_5678); end
      cmp_n++; if (len_q[1] !== TO) begin err_n++; $display("FAIL to_edge_len: got %0d expected %0d", len_q[1], TO); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_logs();
    enqueue(1'b0, 3'd4, $urandom, $urandom, 4'hF, 40, $urandom, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc_n >= 3) begin seen = 1'b1; break; end
    end
    cmp_n++; if (!seen) begin err_n++; $display("FAIL rstmid_reach_access: got %0d access cycles expected 3", acc_n); end
    rst = 1'b1;
    step();
    cmp_n++; if ({bus.psel, bus.penable, rsp_push} !== 3'b000) begin err_n++; $display("FAIL rstmid_ctrl: got %b expected 000", {bus.psel, bus.penable, rsp_push}); end
    cmp_n++; if ({bus.pwrite, bus.pprot, bus.paddr, bus.pwdata, bus.pstrb, rsp_data} !== '0) begin err_n++; $display("FAIL rstmid_data: got %h expected 0", {bus.pwrite, bus.pprot, bus.paddr, bus.pwdata, bus.pstrb, rsp_data}); end
    rst = 1'b0;
    repeat (10) step();
    cmp_n++; if (got_q.size() !== 0) begin err_n++; $display("FAIL rstmid_no_push: got %0d pushes expected 0", got_q.size()); end
    clear_logs();
    enqueue(1'b1, 3'd7, $urandom, $urandom, 4'h9, 2, $urandom, 1'b0);
    wait_rsp(1, 50, ok);
    cmp_n++; if (!ok || got_q[0] !== exp_q[0]) begin err_n++; $display("FAIL rstmid_fresh: got %h expected %h", ok ? got_q[0] : '0, exp_q[0]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] rv;
    localparam int N = 24;
    clear_logs();
    for (int i = 0; i < N; i++) begin
      rv = $urandom;
      enqueue(rv[0], rv[3:1], $urandom, $urandom, rv[7:4], int'($urandom_range(0, 10)), $urandom, rv[8]);
    end
    wait_rsp(N, N * 16 + 50, ok);
    cmp_n++; if (!ok) begin err_n++; $display("FAIL b2b_rsp_count: got %0d expected %0d", got_q.size(), N); end
    else begin
      for (int i = 0; i < N; i++) begin
        cmp_n++; if (got_q[i] !== exp_q[i]) begin err_n++; $display("FAIL b2b_rsp%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        cmp_n++; if (obs_bus_q[i] !== exp_bus_q[i]) begin err_n++; $display("FAIL b2b_bus%0d: got %h expected %h", i, obs_bus_q[i], exp_bus_q[i]); end
        cmp_n++; if (len_q[i] !== exp_len_q[i]) begin err_n++; $display("FAIL b2b_len%0d: got %0d expected %0d", i, len_q[i], exp_len_q[i]); end
        if (i > 0) begin
          cmp_n++; if (pop_cyc_q[i] !== push_cyc_q[i-1] + 1) begin err_n++; $display("FAIL b2b_pop%0d: got %0d expected %0d", i, pop_cyc_q[i], push_cyc_q[i-1] + 1); end
        end
      end
      cmp_n++; if (unstable_n !== 0) begin err_n++; $display("FAIL b2b_stable: got %0d changes expected 0", unstable_n); end
      cmp_n++; if (push_full_n !== 0) begin err_n++; $display("FAIL b2b_push_full: got %0d expected 0", push_full_n); end
    end
  endtask

  initial begin
    test_reset();
    test_write_nowait();
    test_read_wait();
    test_error();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_fifo_master.md
# apb_fifo_master

APB4 requester that drains the bridge's request FIFO and fills its response FIFO. Each popped request word becomes one APB4 transfer (SETUP then ACCESS with wait states). The completion status and read data are packed into a response word and pushed. It sits between the request/response `fifo` instances and the APB bus, opposite the AXI4-Lite front end that writes requests and reads responses.

## Interface
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width (multiple of 8)
- `TIMEOUT`, 256, max ACCESS cycles waiting for `pready`; 0 disables timeout
- `REQ_W`, derived = 1+3+ADDR_W+DATA_W+DATA_W/8; request word {write, prot[2:0], addr, wdata, strb}, MSB first
- `RSP_W`, derived = 2+DATA_W; response word {write, slverr, rdata}
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_empty`  in  1  request FIFO empty
- `req_data`  in  REQ_W  request FIFO read data, valid in the cycle `req_pop` is high
- `req_pop`  out  1  pop request FIFO
- `rsp_full`  in  1  response FIFO full
- `rsp_push`  out  1  push response FIFO
- `rsp_data`  out  RSP_W  response word
- `psel`, `penable`, `pwrite`  out  1  APB4 control
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  write data
- `pstrb`  out  DATA_W/8  write strobes
- `pprot`  out  3  protection
- `pready`, `pslverr`  in  1  completer handshake and error
- `prdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If `!req_empty && !rsp_full`: assert `req_pop` for one cycle, register every `req_data` field that cycle, go to SETUP.
  - Otherwise stay in IDLE; `req_pop` stays low.
- SETUP: `psel=1`, `penable=0`, address/control/data from the registered request; go to ACCESS.
- ACCESS:
  - `psel=1`, `penable=1`; all bus outputs stay stable.
  - On `pready=1`: capture `prdata` (reads only; 0 for writes) and `pslverr`, go to RESP.
- Timeout:
  - If `TIMEOUT!=0` and the wait counter reaches TIMEOUT-1 with `pready=0`, go to RESP with slverr=1 and rdata=0.
  - `psel`/`penable` drop on the next cycle.
- RESP: `psel=0`, `penable=0`; assert `rsp_push` for one cycle with the registered response; go to IDLE.
- Response space: only this block pushes into the response FIFO, so `!rsp_full` checked at pop guarantees a free slot at RESP. `rsp_push` never coincides with `rsp_full=1`.
- Strobes and protection:
  - Reads drive `pstrb=0` regardless of the request's strb field.
  - `pprot` is taken verbatim from the request.
- Order: responses leave in request order; exactly one response per popped request; at most one transfer outstanding.

## Timing
- Reset values: `req_pop`=0, `rsp_push`=0, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `pstrb`=0, `pprot`=0, `rsp_data`=0; FSM in IDLE; wait counter 0.
- All outputs are registered or decoded from registered state only; no combinational path from APB inputs to outputs.
- Latency from pop to SETUP is 1 cycle. With zero wait states, the ACCESS cycle follows 1 cycle after SETUP, and RESP follows 1 cycle after ACCESS. Minimum 4 cycles per request (IDLE, SETUP, ACCESS, RESP).
- N wait states add N cycles in ACCESS.
- Wait counter:
  - Width `$clog2(TIMEOUT+1)`.
  - Clears on entry to ACCESS; increments each ACCESS cycle with `pready=0`.
  - Saturates, never wraps.
- `pready` and the timeout limit in the same cycle: `pready` wins, normal completion with the completer's `pslverr`.
- Reset mid-transfer: `psel`/`penable` are 0 in the cycle after `rst` is sampled. The in-flight request is discarded and no response is pushed.
- `pslverr` is sampled only when `psel&&penable&&pready`; it is ignored otherwise.

## Structure
- Shared package `apb_bridge_pkg` holds:
  - the FSM state enum (`apb_state_t`);
  - field offset/width localparams for request and response words;
  - pack/unpack functions, so the AXI4-Lite front end uses identical layouts.
- Timeout logic stays inline; no sub-module needed. The two FIFOs are instantiated at top level, not inside this block.

## Test plan
- Write, no wait: request {write=1, prot=0, addr=0x10, wdata=0xDEADBEEF, strb=0xF}, `pready` tied high.
  - `psel` rises 1 cycle after `req_pop`; `penable` rises the next cycle.
  - `rsp_push` fires 1 cycle after ACCESS with rsp_data {1,0,0x0}.
- Read, 3 wait states: addr=0x24, `prdata`=0xA5A5A5A5 with `pready` high on the 4th ACCESS cycle.
  - `pstrb=0` throughout.
  - Response {0,0,0xA5A5A5A5}; ACCESS lasts exactly 4 cycles.
- Error: write with `pslverr=1` at completion.
  - Response {1,1,0}; next request is not popped until RESP has passed.
- Backpressure: `rsp_full=1` with 3 requests queued.
  - No `req_pop` and `psel` stays 0.
  - After `rsp_full` clears: 3 transfers complete and 3 responses are pushed in order.
- Timeout: TIMEOUT=8, `pready` held low.
  - After 8 ACCESS cycles, bus goes idle and response {x,1,0} is pushed.
  - Repeat with `pready` rising on the 8th cycle: normal completion.
- Reset mid-ACCESS: assert `rst` during a wait state.
  - All outputs are at reset values the next cycle; no `rsp_push` occurs.
  - A fresh request after reset completes normally.
